// File: rtl/vector_sequencer_pkg.sv
// Shared definitions for the vector sequencer: FSM encoding, record widths and defaults.
package vector_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    localparam int NPIS_DEF       = 14;
    localparam int NPOS_DEF       = 11;
    localparam int SETTLE_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int MIN_SETTLE     = 3;
    localparam int INDEX_W        = 16;
    localparam int COUNT_W        = 16;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/vector_sequencer_if.sv
// Parser-facing bundle: vector offer, result record, counters and control pulses.
interface vector_sequencer_if
    import vector_sequencer_pkg::*;
#(
    parameter int NPIS = NPIS_DEF,
    parameter int NPOS = NPOS_DEF
);
    logic               vec_valid;
    logic               vec_ready;
    logic [NPIS-1:0]    vec_pis;
    logic [NPOS-1:0]    vec_exp;
    logic [NPOS-1:0]    vec_mask;
    logic               res_valid;
    logic               res_ready;
    logic [NPOS-1:0]    res_pos;
    logic               res_fail;
    logic [INDEX_W-1:0] res_index;
    logic [COUNT_W-1:0] fail_count;
    logic               clear;
    logic               flush;
    logic               busy;

    modport master (
        output vec_valid, vec_pis, vec_exp, vec_mask, res_ready, clear, flush,
        input  vec_ready, res_valid, res_pos, res_fail, res_index, fail_count, busy
    );

    modport slave (
        input  vec_valid, vec_pis, vec_exp, vec_mask, res_ready, clear, flush,
        output vec_ready, res_valid, res_pos, res_fail, res_index, fail_count, busy
    );
endinterface

// File: rtl/vector_sequencer_fifo.sv
// Synchronous vector queue with registered count; flush empties it in one cycle.
module vec_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vector_sequencer.sv
// Applies queued test vectors to the part, waits for settling, captures and compares the outputs.
//   state   | meaning
//   IDLE    | waiting for a queued vector; pops and applies it
//   SETTLE  | vector applied, counting down the settle time
//   CAPTURE | sample synchronised outputs, compare, update counters
//   REPORT  | result record held until the parser takes it
module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int NPIS          = NPIS_DEF,
    parameter int NPOS          = NPOS_DEF,
    parameter int SETTLE_CYCLES = SETTLE_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    vector_sequencer_if.slave   bus,
    output logic [NPIS-1:0]     part_pis,
    input  logic [NPOS-1:0]     part_pos
);
    localparam int EW = NPIS + 2 * NPOS;
    localparam int CW = $clog2(SETTLE_CYCLES);

    if (SETTLE_CYCLES < MIN_SETTLE) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least %0d", MIN_SETTLE);
    end
    if (FIFO_DEPTH < 2 || !is_pow2(FIFO_DEPTH)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    state_t             state;
    logic [CW-1:0]      settle_cnt;
    logic [NPOS-1:0]    pos_meta;
    logic [NPOS-1:0]    pos_sync;
    logic [NPOS-1:0]    exp_q;
    logic [NPOS-1:0]    mask_q;
    logic [INDEX_W-1:0] index;
    logic [COUNT_W-1:0] fail_count;
    logic               res_valid;
    logic [NPOS-1:0]    res_pos;
    logic               res_fail;
    logic [INDEX_W-1:0] res_index;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               mismatch;
    logic [EW-1:0]      head;
    logic [NPIS-1:0]    head_pis;
    logic [NPOS-1:0]    head_exp;
    logic [NPOS-1:0]    head_mask;

    assign bus.vec_ready  = !full && !bus.flush;
    assign push           = bus.vec_valid && bus.vec_ready;
    assign pop            = (state == IDLE) && !empty && !bus.flush;
    assign {head_pis, head_exp, head_mask} = head;
    assign mismatch       = |((pos_sync ^ exp_q) & mask_q);

    assign bus.res_valid  = res_valid;
    assign bus.res_pos    = res_pos;
    assign bus.res_fail   = res_fail;
    assign bus.res_index  = res_index;
    assign bus.fail_count = fail_count;
    assign bus.busy       = (state != IDLE) || !empty;

    vec_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (bus.flush),
        .wr_data ({bus.vec_pis, bus.vec_exp, bus.vec_mask}),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_meta <= '0;
            pos_sync <= '0;
        end else begin
            pos_meta <= part_pos;
            pos_sync <= pos_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            part_pis   <= '0;
            index      <= '0;
            fail_count <= '0;
            res_valid  <= 1'b0;
            res_pos    <= '0;
            res_fail   <= 1'b0;
            res_index  <= '0;
        end else begin
            // Counters advance on capture even when a flush discards the record; clear overrides.
            if (state == CAPTURE) begin
                index <= index + INDEX_W'(1);
                if (mismatch && fail_count != '1) fail_count <= fail_count + COUNT_W'(1);
            end
            if (bus.clear) begin
                index      <= '0;
                fail_count <= '0;
            end

            if (bus.flush) begin
                state     <= IDLE;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (!empty) begin
                        part_pis   <= head_pis;
                        exp_q      <= head_exp;
                        mask_q     <= head_mask;
                        settle_cnt <= CW'(SETTLE_CYCLES - 1);
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt == '0) state <= CAPTURE;
                        else settle_cnt <= settle_cnt - CW'(1);
                    end
                    CAPTURE: begin
                        res_pos   <= pos_sync;
                        res_fail  <= mismatch;
                        res_index <= index;
                        res_valid <= 1'b1;
                        state     <= REPORT;
                    end
                    REPORT: if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
